// File: rtl/sine_voice_scheduler.sv
// Shares one registered quarter-wave sine ROM among NUM_VOICES phase-accumulator voices and mixes them into one sample per request.
// Build option: define SINE_SCHED_SATURATE_EN to output the full-scale sum clipped to 16 bits instead of the averaged sum.
module sine_voice_scheduler #(
    parameter int NUM_VOICES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       generate_next,
    input  logic [20*NUM_VOICES-1:0]   step_sizes,
    input  logic [NUM_VOICES-1:0]      voice_en,
    output logic [9:0]                 rom_addr,
    input  logic [15:0]                rom_data,
    output logic [15:0]                sample,
    output logic                       sample_ready,
    output logic                       busy,
    output logic                       overrun
);
    localparam int LOG2  = $clog2(NUM_VOICES);
    localparam int VW    = (LOG2 > 0) ? LOG2 : 1;
    localparam int ACC_W = 16 + LOG2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, DONE} state_t;

    state_t                   state, state_nxt;
    logic [VW-1:0]            v;
    logic [21:0]              phase [NUM_VOICES];
    logic [21:0]              cur_phase;
    logic [19:0]              cur_step;
    logic [1:0]               q_lat;
    logic                     last_voice;
    logic signed [ACC_W-1:0]  acc, acc_nxt, term, rom_ext;
    logic [15:0]              sample_val;

    assign cur_phase  = phase[v];
    assign cur_step   = step_sizes[20*v +: 20];
    assign last_voice = (v == VW'(NUM_VOICES-1));
    assign rom_ext    = ACC_W'(rom_data);

    // Disabled voices still spend their three cycles but add nothing.
    always_comb begin
        term = '0;
        if (voice_en[v])
            term = q_lat[1] ? -rom_ext : rom_ext;
        acc_nxt = acc + term;
    end

`ifdef SINE_SCHED_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
    always_comb begin
        sample_val = acc_nxt[15:0];
        if (acc_nxt > SAT_MAX)
            sample_val = 16'h7FFF;
        else if (acc_nxt < SAT_MIN)
            sample_val = 16'h8000;
    end
`else
    logic signed [ACC_W-1:0] acc_shr;
    always_comb begin
        acc_shr    = acc_nxt >>> LOG2;
        sample_val = acc_shr[15:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (generate_next) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = ACC;
            ACC:     state_nxt = last_voice ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        sample_ready = (state == DONE);
    end

    // sample is loaded on the way into DONE so it is already valid while sample_ready is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            v        <= '0;
            acc      <= '0;
            sample   <= '0;
            rom_addr <= '0;
            q_lat    <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++)
                phase[i] <= '0;
        end else begin
            if (generate_next && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (generate_next) begin
                    v   <= '0;
                    acc <= '0;
                end
                ISSUE: begin
                    q_lat    <= cur_phase[21:20];
                    rom_addr <= cur_phase[20] ? ~cur_phase[19:10] : cur_phase[19:10];
                end
                ACC: begin
                    acc <= acc_nxt;
                    if (voice_en[v])
                        phase[v] <= cur_phase + {2'b00, cur_step};
                    if (last_voice)
                        sample <= sample_val;
                    else
                        v <= v + VW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler (4 voices) against a {0,addr,00000} registered ROM model.
module tb_sine_voice_scheduler;
    logic        clk = 1'b0;
    logic        reset, generate_next;
    logic [79:0] step_sizes;
    logic [3:0]  voice_en;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data, sample;
    logic        sample_ready, busy, overrun;

    sine_voice_scheduler #(.NUM_VOICES(4)) dut (
        .clk(clk), .reset(reset), .generate_next(generate_next),
        .step_sizes(step_sizes), .voice_en(voice_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .sample(sample), .sample_ready(sample_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= {1'b0, rom_addr, 5'b00000};

    typedef struct {
        logic [15:0] s;
        int          due;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    logic [9:0] addr0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output for a hand-computed full-scale voice sum.
    function automatic logic [15:0] mix(input int sum);
        int sh;
`ifdef SINE_SCHED_SATURATE_EN
        if (sum > 32767) return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
        sh = sum;
`else
        sh = sum >>> 2;
`endif
        return sh[15:0];
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample_ready: got sample %0d expected no pulse (cycle %0d)", $signed(sample), cyc);
            end else begin
                e = sb.pop_front();
                chk("sample", $signed(sample), $signed(e.s));
                chk("ready_cycle", cyc, e.due);
            end
        end
    end

    // Called on a negedge; returns on the negedge 14 cycles later, when the FSM is idle again.
    task automatic req(input int sum);
        sb.push_back('{mix(sum), cyc + 13});
        generate_next = 1'b1;
        @(negedge clk) generate_next = 1'b0;
        @(negedge clk) addr0 = rom_addr;
        repeat (12) @(negedge clk);
    endtask

    int t1 [17] = '{0, 8192, 16384, 24576, 32736, 24544, 16352, 8160, 0,
                    -8192, -16384, -24576, -32736, -24544, -16352, -8160, 0};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; generate_next = 1'b0; step_sizes = '0; voice_en = '0;
        repeat (3) @(negedge clk);
        chk("rst_sample", sample, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ready", sample_ready, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single voice walking the full cycle, including the wrap back to 0.
        voice_en = 4'b0001; step_sizes = {4{20'h40000}};
        for (int i = 0; i < 17; i++) begin
            req(t1[i]);
            if (i == 9) chk("rom_addr_lower", addr0, 256);
        end

        // Bring voices 1..3 to 0x040000 (voice 0 already there).
        voice_en = 4'b1110;
        req(0);
        voice_en = 4'b1111; step_sizes = '0;
        req(32768);
        voice_en = 4'b0101; step_sizes = {4{20'h40000}};
        req(16384);
        // Voices 0,2 advanced to 0x080000; voices 1,3 must still be at 0x040000.
        voice_en = 4'b1111; step_sizes = '0;
        req(49152);

        // Move every voice to 0x0FFC00 (addr 1023).
        step_sizes = {20'hBFC00, 20'h7FC00, 20'hBFC00, 20'h7FC00};
        req(49152);
        step_sizes = '0;
        req(130944);

        // Overrun: second request at cycle 5 is dropped.
        sb.push_back('{mix(130944), cyc + 13});
        generate_next = 1'b1;
        @(negedge clk) generate_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("overrun_before", overrun, 0);
        generate_next = 1'b1;
        @(negedge clk) generate_next = 1'b0;
        chk("overrun_set", overrun, 1);
        repeat (8) @(negedge clk);
        chk("busy_after_done", busy, 0);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", overrun, 1);

        // Reset in cycle 7 of a sequence: nothing may come out of it.
        generate_next = 1'b1;
        @(negedge clk) generate_next = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_sample", sample, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_overrun", overrun, 0);
        repeat (20) @(negedge clk);
        step_sizes = {4{20'h40000}};
        req(0);
        step_sizes = '0;
        req(32768);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
